// File: rtl/ps2_transmit_if.sv
// Command handshake between a PS/2 host controller and ps2_transmit:
// byte/request in, busy/done/error status back.
interface ps2_transmit_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_transmit.sv
// Host-to-device PS/2 transmitter: request-to-send, device-clocked frame, ACK check.
// Optional watchdog from clock release to frame end enabled by `define PS2_TX_TIMEOUT_EN.
module ps2_transmit #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe,
    ps2_transmit_if.slave tx
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t          state_r;
    logic            clk_meta_r;
    logic            clk_sync_r;
    logic            data_meta_r;
    logic            data_sync_r;
    logic            clk_prev_r;
    logic            fall_r;
    logic            edge_mask_s;
    logic [IW-1:0]   inhibit_cnt_r;
    logic [3:0]      bit_cnt_r;
    logic [7:0]      byte_r;
    logic            parity_r;
    logic            clk_oe_r;
    logic            data_oe_r;
    logic            busy_r;
    logic            done_r;
    logic            error_r;

    // Host drives the clock low itself in these states; those edges are not device clocks.
    assign edge_mask_s = (state_r == INHIBIT) || (state_r == RTS);

    // Pad synchronisers and registered falling-edge detect on the device clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
            clk_prev_r  <= 1'b1;
            fall_r      <= 1'b0;
        end else begin
            clk_meta_r  <= ps2_clk_in;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
            clk_prev_r  <= clk_sync_r;
            fall_r      <= edge_mask_s ? 1'b0 : (clk_prev_r & ~clk_sync_r);
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    // Fires so that done lands exactly TIMEOUT_CYCLES cycles after the RTS cycle.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 2);

    logic [WW-1:0] wd_r;
    logic          watch_s;
    logic          timeout_s;

    assign watch_s   = (state_r == SHIFT) || (state_r == ACK) || (state_r == WAIT_IDLE);
    assign timeout_s = watch_s && (wd_r == WD_LAST);

    // Watchdog: cleared at clock release, runs while waiting on the device.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_r <= '0;
        end else if (state_r == RTS) begin
            wd_r <= '0;
        end else if (watch_s) begin
            wd_r <= wd_r + {{(WW-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= wd_r;
        end
    end
`endif

    // Transmit sequencer with registered line drives and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            inhibit_cnt_r <= '0;
            bit_cnt_r     <= 4'd0;
            byte_r        <= 8'd0;
            parity_r      <= 1'b0;
            clk_oe_r      <= 1'b0;
            data_oe_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            if (timeout_s) begin
                clk_oe_r  <= 1'b0;
                data_oe_r <= 1'b0;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                error_r   <= 1'b1;
                state_r   <= IDLE;
            end else
`endif
            case (state_r)
                IDLE: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    if (tx.tx_start) begin
                        byte_r        <= tx.tx_data;
                        parity_r      <= ~^tx.tx_data;
                        inhibit_cnt_r <= '0;
                        clk_oe_r      <= 1'b1;
                        busy_r        <= 1'b1;
                        error_r       <= 1'b0;
                        state_r       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inhibit_cnt_r == INHIBIT_LAST) begin
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b1;
                        state_r   <= RTS;
                    end else begin
                        inhibit_cnt_r <= inhibit_cnt_r + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                RTS: begin
                    bit_cnt_r <= 4'd0;
                    state_r   <= SHIFT;
                end
                SHIFT: begin
                    // Line is an open-collector pull: oe = 1 puts a 0 on the wire.
                    if (fall_r) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r < 4'd8) begin
                            data_oe_r <= ~byte_r[bit_cnt_r[2:0]];
                        end else if (bit_cnt_r == 4'd8) begin
                            data_oe_r <= ~parity_r;
                        end else begin
                            data_oe_r <= 1'b0;
                            state_r   <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall_r) begin
                        error_r <= data_sync_r;
                        state_r <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync_r && data_sync_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign tx.busy     = busy_r;
    assign tx.done     = done_r;
    assign tx.error    = error_r;

endmodule

// File: tb/tb_ps2_transmit.sv
// Directed + randomized bench for ps2_transmit with an open-collector bus and a PS/2 device model.
module tb_ps2_transmit;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 2000;
    localparam int H       = 25;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low, dev_data_low;
    logic clk_line, data_line;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_gaps = 0;
    logic err_seen = 1'b0;
    logic track_busy = 1'b0;

    ps2_transmit_if tx_if ();

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_transmit #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx          (tx_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling clock edge and record done/busy activity.
    task automatic tick();
        @(negedge clk);
        if (tx_if.done) begin
            done_cnt++;
            err_seen   = tx_if.error;
            track_busy = 1'b0;
        end else if (track_busy && !tx_if.busy) begin
            busy_gaps++;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Expected wire frame, index = sample order: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Request a send and measure the inhibit phase; leaves the bus at clock release.
    task automatic start_send(input logic [7:0] d, input string name);
        int cnt;
        tx_if.tx_data  = d;
        tx_if.tx_start = 1'b1;
        tick();
        tx_if.tx_start = 1'b0;
        track_busy     = 1'b1;
        busy_gaps      = 0;
        cnt = 0;
        while (ps2_clk_oe && cnt < INHIBIT + 1000) begin
            cnt++;
            tick();
        end
        check({name, "_inhibit_len"}, cnt, INHIBIT);
        check({name, "_start_bit_oe"}, int'(ps2_data_oe), 1);
    endtask

    // Device model: one clock pulse, sampling the data line just before the rising edge.
    task automatic dev_pulse(output logic sample);
        ticks(H);
        dev_clk_low = 1'b1;
        ticks(H);
        sample = data_line;
        dev_clk_low = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ack, input bit inject, input string name);
        logic [10:0] obs;
        logic        s;
        int          base;
        int          cnt;
        base = done_cnt;
        start_send(d, name);
        obs[0] = data_line;
        for (int i = 1; i <= 10; i++) begin
            if (inject && i == 4) begin
                tx_if.tx_data  = 8'h55;
                tx_if.tx_start = 1'b1;
                tick();
                tx_if.tx_start = 1'b0;
                tx_if.tx_data  = d;
            end
            dev_pulse(s);
            obs[i] = s;
        end
        check({name, "_frame"}, int'(obs), int'(model_frame(d)));
        dev_data_low = ack;
        dev_pulse(s);
        ticks(4);
        dev_data_low = 1'b0;
        cnt = 0;
        while (done_cnt == base && cnt < 60) begin
            cnt++;
            tick();
        end
        ticks(20);
        check({name, "_done_pulses"}, done_cnt - base, 1);
        check({name, "_error"}, int'(err_seen), ack ? 0 : 1);
        check({name, "_busy_gaps"}, busy_gaps, 0);
        check({name, "_lines_released"}, int'({ps2_clk_oe, ps2_data_oe}), 0);
        check({name, "_busy_after"}, int'(tx_if.busy), 0);
    endtask

    initial begin
        logic        s;
        logic [7:0]  rb;
        int          base;
        int          cnt;
        reset          = 1'b1;
        dev_clk_low    = 1'b0;
        dev_data_low   = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_start = 1'b0;
        ticks(3);
        check("reset_lines", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check("reset_status", int'({tx_if.busy, tx_if.done, tx_if.error}), 0);
        reset = 1'b0;
        ticks(3);

        send_frame(8'hED, 1'b1, 1'b0, "ed_ack");
        send_frame(8'hF4, 1'b1, 1'b0, "f4_ack");
        send_frame(8'h00, 1'b0, 1'b0, "00_nack");
        send_frame(8'hED, 1'b1, 1'b1, "ed_ignore_55");

        // Reset part-way through the data bits: lines release at once, no done.
        base = done_cnt;
        start_send(8'hED, "abort");
        for (int i = 1; i <= 4; i++) dev_pulse(s);
        ticks(8);
        #3 reset = 1'b1;
        #1;
        check("abort_lines", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check("abort_busy", int'(tx_if.busy), 0);
        track_busy = 1'b0;
        ticks(2);
        reset = 1'b0;
        ticks(20);
        check("abort_no_done", done_cnt - base, 0);

        send_frame(8'hF4, 1'b1, 1'b0, "f4_after_abort");

        for (int r = 0; r < 2; r++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, bit'($urandom_range(0, 1)), 1'b0, "random");
        end

        // Device never clocks after release.
        base = done_cnt;
        start_send(8'hA5, "silent");
`ifdef PS2_TX_TIMEOUT_EN
        cnt = 0;
        while (done_cnt == base && cnt < TIMEOUT + 500) begin
            tick();
            cnt++;
        end
        check("timeout_latency", cnt, TIMEOUT);
        check("timeout_error", int'(err_seen), 1);
        check("timeout_lines", int'({ps2_clk_oe, ps2_data_oe}), 0);
`else
        ticks(12000);
        check("silent_busy_gaps", busy_gaps, 0);
        check("silent_no_done", done_cnt - base, 0);
        check("silent_busy", int'(tx_if.busy), 1);
`endif
        track_busy = 1'b0;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
